riscv_test_monitor: RTL and testbench



---
 rtl/riscv_test_monitor_pkg.sv | 30 +++
 rtl/riscv_test_monitor_sat_cnt.sv | 25 ++
 rtl/riscv_test_monitor.sv | 159 +++++++++++++++
 tb/tb_riscv_test_monitor.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_test_monitor_pkg.sv
// Shared definitions for the core bring-up test monitor.
//   - state_e  : monitor FSM encoding (IDLE -> RUN -> DONE)
//   - result_e : terminal result codes, usable as a compact status register
//   - DEFAULT_PASS_PC / DEFAULT_FAIL_PC : conventional end-of-test fetch PCs
//   - cnt_width : width needed to hold 0..max_val (at least 1 bit)
package riscv_test_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        RES_NONE    = 3'd0,
        RES_PASS    = 3'd1,
        RES_FAIL    = 3'd2,
        RES_TIMEOUT = 3'd3,
        RES_HANG    = 3'd4,
        RES_PROTO   = 3'd5
    } result_e;

    localparam logic [31:0] DEFAULT_PASS_PC = 32'h8000012c;
    localparam logic [31:0] DEFAULT_FAIL_PC = 32'h80000130;

    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val > 0) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/riscv_test_monitor_sat_cnt.sv
// Saturating up-counter with synchronous clear.
//   clk   : clock
//   rst   : synchronous active-high reset, count returns to 0
//   clr   : clear to 0 (wins over inc)
//   inc   : increment by one, holding at all-ones
//   count : current value
module riscv_test_monitor_sat_cnt #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/riscv_test_monitor.sv
// Pass/fail/timeout/hang monitor snooping the core instruction-fetch port.
// Watches the fetch handshake in parallel with the instruction memory and
// latches exactly one sticky terminal flag, after which everything freezes
// until reset.
//   clk_i, rst_i        : clock, synchronous active-high reset
//   mem_i_rd_i          : fetch request
//   mem_i_accept_i      : memory accepts the request this cycle
//   mem_i_valid_i       : fetch response valid
//   mem_i_error_i       : fetch response error (meaningful with valid only)
//   mem_i_pc_i          : fetch PC
//   mem_i_inst_i        : fetch response data
//   done_o              : monitor reached DONE
//   pass_o / fail_o / timeout_o / hang_o / proto_err_o : terminal flags
//   cycle_count_o       : RUN cycles, saturating
//   fetch_count_o       : accepted fetches, saturating
//   last_pc_o           : PC of most recent accepted fetch
//   last_inst_o         : data of most recent response
module riscv_test_monitor
    import riscv_test_monitor_pkg::*;
#(
    parameter logic [31:0] PASS_PC         = DEFAULT_PASS_PC,
    parameter logic [31:0] FAIL_PC         = DEFAULT_FAIL_PC,
    parameter int unsigned TIMEOUT_CYCLES  = 1000,
    parameter int unsigned HANG_CYCLES     = 256,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_i_rd_i,
    input  logic        mem_i_accept_i,
    input  logic        mem_i_valid_i,
    input  logic        mem_i_error_i,
    input  logic [31:0] mem_i_pc_i,
    input  logic [63:0] mem_i_inst_i,
    output logic        done_o,
    output logic        pass_o,
    output logic        fail_o,
    output logic        timeout_o,
    output logic        hang_o,
    output logic        proto_err_o,
    output logic [31:0] cycle_count_o,
    output logic [31:0] fetch_count_o,
    output logic [31:0] last_pc_o,
    output logic [63:0] last_inst_o
);

    localparam int unsigned STALL_W = cnt_width(HANG_CYCLES);
    // One spare count above the legal maximum so an overflow is observable.
    localparam int unsigned OUT_W   = cnt_width(MAX_OUTSTANDING + 1);

    state_e             state_q, state_d;
    result_e            result_q, result_d, term;
    logic [OUT_W-1:0]   outstanding_q;
    logic [OUT_W:0]     out_sum, out_net;
    logic [31:0]        last_pc_q;
    logic [63:0]        last_inst_q;
    logic [STALL_W-1:0] stall_count;

    logic acc_ev, resp_ev, live, processing, new_pc;
    logic proto, fail_hit, pass_hit, timeout_hit, hang_hit;

    assign acc_ev     = mem_i_rd_i & mem_i_accept_i;
    assign resp_ev    = mem_i_valid_i;
    assign processing = (state_q != ST_DONE);
    // The accept that leaves IDLE is itself RUN cycle 1.
    assign live       = (state_q == ST_RUN) || ((state_q == ST_IDLE) && acc_ev);
    assign new_pc     = acc_ev && (mem_i_pc_i != last_pc_q);

    // Underflow wraps out_net to a large value, which also trips the
    // overflow compare; both are protocol errors so no special case needed.
    assign out_sum = {1'b0, outstanding_q} + {{OUT_W{1'b0}}, acc_ev};
    assign out_net = out_sum - {{OUT_W{1'b0}}, resp_ev};

    assign proto = (resp_ev && (outstanding_q == '0))
                || (out_net > (OUT_W + 1)'(MAX_OUTSTANDING))
                || (mem_i_accept_i && !mem_i_rd_i);

    assign fail_hit    = (acc_ev && (mem_i_pc_i == FAIL_PC)) || (resp_ev && mem_i_error_i);
    assign pass_hit    = acc_ev && (mem_i_pc_i == PASS_PC);
    // Checks look at the pre-increment value so the flag lands on the same
    // edge the counter reaches its limit.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cycle_count_o == TIMEOUT_CYCLES - 1);
    assign hang_hit    = (HANG_CYCLES != 0) && !new_pc
                      && (32'(stall_count) == HANG_CYCLES - 1);

    riscv_test_monitor_sat_cnt #(.W(32)) u_cycle_cnt (
        .clk   (clk_i),
        .rst   (rst_i),
        .clr   (1'b0),
        .inc   (live),
        .count (cycle_count_o)
    );

    riscv_test_monitor_sat_cnt #(.W(32)) u_fetch_cnt (
        .clk   (clk_i),
        .rst   (rst_i),
        .clr   (1'b0),
        .inc   (live && acc_ev),
        .count (fetch_count_o)
    );

    // Refetching the same PC is a stall, so tight self-loops register as hangs.
    riscv_test_monitor_sat_cnt #(.W(STALL_W)) u_stall_cnt (
        .clk   (clk_i),
        .rst   (rst_i),
        .clr   (live && new_pc),
        .inc   (live && !new_pc),
        .count (stall_count)
    );

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        term     = RES_NONE;
        if (processing) begin
            if (proto) begin
                term = RES_PROTO;
            end else if (live) begin
                state_d = ST_RUN;
                if (fail_hit)         term = RES_FAIL;
                else if (pass_hit)    term = RES_PASS;
                else if (timeout_hit) term = RES_TIMEOUT;
                else if (hang_hit)    term = RES_HANG;
            end
            if (term != RES_NONE) begin
                state_d  = ST_DONE;
                result_d = term;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            result_q      <= RES_NONE;
            outstanding_q <= '0;
            last_pc_q     <= '0;
            last_inst_q   <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            if (processing) begin
                outstanding_q <= out_net[OUT_W-1:0];
                if (acc_ev)  last_pc_q   <= mem_i_pc_i;
                if (resp_ev) last_inst_q <= mem_i_inst_i;
            end
        end
    end

    assign done_o      = (state_q == ST_DONE);
    assign pass_o      = (result_q == RES_PASS);
    assign fail_o      = (result_q == RES_FAIL);
    assign timeout_o   = (result_q == RES_TIMEOUT);
    assign hang_o      = (result_q == RES_HANG);
    assign proto_err_o = (result_q == RES_PROTO);
    assign last_pc_o   = last_pc_q;
    assign last_inst_o = last_inst_q;

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Scoreboard bench for riscv_test_monitor. Two instances share one stimulus
// stream: u_a has the hang check disabled, u_b uses a short hang limit.
module tb_riscv_test_monitor;

    localparam logic [31:0] PASS_PC = 32'h8000012c;
    localparam logic [31:0] FAIL_PC = 32'h80000130;

    // Flag vector order: {pass, fail, timeout, hang, proto}
    localparam logic [4:0] F_PASS  = 5'b10000;
    localparam logic [4:0] F_FAIL  = 5'b01000;
    localparam logic [4:0] F_TOUT  = 5'b00100;
    localparam logic [4:0] F_HANG  = 5'b00010;
    localparam logic [4:0] F_PROTO = 5'b00001;

    typedef struct {
        string       name;
        logic [4:0]  flags;
        logic [31:0] cycles;
        logic [31:0] fetches;
        logic [31:0] last_pc;
        logic [63:0] last_inst;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd = 1'b0, accept = 1'b0, valid = 1'b0, error = 1'b0;
    logic [31:0] pc = '0;
    logic [63:0] inst = '0;

    logic        done_a, pass_a, fail_a, tout_a, hang_a, proto_a;
    logic [31:0] cyc_a, fet_a, lpc_a;
    logic [63:0] linst_a;
    logic        done_b, pass_b, fail_b, tout_b, hang_b, proto_b;
    logic [31:0] cyc_b, fet_b, lpc_b;
    logic [63:0] linst_b;
    logic [4:0]  flags_a, flags_b;

    assign flags_a = {pass_a, fail_a, tout_a, hang_a, proto_a};
    assign flags_b = {pass_b, fail_b, tout_b, hang_b, proto_b};

    exp_t q_a[$];
    exp_t q_b[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    riscv_test_monitor #(
        .PASS_PC(PASS_PC), .FAIL_PC(FAIL_PC),
        .TIMEOUT_CYCLES(1000), .HANG_CYCLES(0), .MAX_OUTSTANDING(2)
    ) u_a (
        .clk_i(clk), .rst_i(rst),
        .mem_i_rd_i(rd), .mem_i_accept_i(accept), .mem_i_valid_i(valid),
        .mem_i_error_i(error), .mem_i_pc_i(pc), .mem_i_inst_i(inst),
        .done_o(done_a), .pass_o(pass_a), .fail_o(fail_a), .timeout_o(tout_a),
        .hang_o(hang_a), .proto_err_o(proto_a),
        .cycle_count_o(cyc_a), .fetch_count_o(fet_a),
        .last_pc_o(lpc_a), .last_inst_o(linst_a)
    );

    riscv_test_monitor #(
        .PASS_PC(PASS_PC), .FAIL_PC(FAIL_PC),
        .TIMEOUT_CYCLES(1000), .HANG_CYCLES(16), .MAX_OUTSTANDING(2)
    ) u_b (
        .clk_i(clk), .rst_i(rst),
        .mem_i_rd_i(rd), .mem_i_accept_i(accept), .mem_i_valid_i(valid),
        .mem_i_error_i(error), .mem_i_pc_i(pc), .mem_i_inst_i(inst),
        .done_o(done_b), .pass_o(pass_b), .fail_o(fail_b), .timeout_o(tout_b),
        .hang_o(hang_b), .proto_err_o(proto_b),
        .cycle_count_o(cyc_b), .fetch_count_o(fet_b),
        .last_pc_o(lpc_b), .last_inst_o(linst_b)
    );

    function automatic exp_t mk(input string name, input logic [4:0] flags,
                                input logic [31:0] cycles, input logic [31:0] fetches,
                                input logic [31:0] last_pc, input logic [63:0] last_inst);
        exp_t e;
        e.name = name; e.flags = flags; e.cycles = cycles;
        e.fetches = fetches; e.last_pc = last_pc; e.last_inst = last_inst;
        return e;
    endfunction

    function automatic logic [63:0] inst_of(input logic [31:0] p);
        return {~p, p};
    endfunction

    task automatic check(input string what, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", what, act, exp);
        end
    endtask

    task automatic mon_cmp(input string tag, input exp_t e, input logic done,
                           input logic [4:0] fl, input logic [31:0] cy,
                           input logic [31:0] fe, input logic [31:0] lp,
                           input logic [63:0] li);
        check({tag, e.name, "/done+flags"}, 64'({done, fl}), 64'({1'b1, e.flags}));
        check({tag, e.name, "/cycles"},     64'(cy), 64'(e.cycles));
        check({tag, e.name, "/fetches"},    64'(fe), 64'(e.fetches));
        check({tag, e.name, "/last_pc"},    64'(lp), 64'(e.last_pc));
        check({tag, e.name, "/last_inst"},  li, e.last_inst);
    endtask

    // Monitors: compare when done rises, and again four cycles later to
    // confirm the result stays frozen under continued bus activity.
    exp_t hold_a, hold_b;
    int   frz_a = 0, frz_b = 0;
    logic prev_a = 1'b0, prev_b = 1'b0;

    always @(negedge clk) begin
        if (done_a && !prev_a) begin
            if (q_a.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL A/unexpected_done: actual=done required=no_done");
            end else begin
                hold_a = q_a.pop_front();
                mon_cmp("A/", hold_a, done_a, flags_a, cyc_a, fet_a, lpc_a, linst_a);
                frz_a = 4;
            end
        end else if (frz_a > 0) begin
            frz_a--;
            if (frz_a == 0)
                mon_cmp("A/frozen/", hold_a, done_a, flags_a, cyc_a, fet_a, lpc_a, linst_a);
        end
        prev_a = done_a;
    end

    always @(negedge clk) begin
        if (done_b && !prev_b) begin
            if (q_b.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL B/unexpected_done: actual=done required=no_done");
            end else begin
                hold_b = q_b.pop_front();
                mon_cmp("B/", hold_b, done_b, flags_b, cyc_b, fet_b, lpc_b, linst_b);
                frz_b = 4;
            end
        end else if (frz_b > 0) begin
            frz_b--;
            if (frz_b == 0)
                mon_cmp("B/frozen/", hold_b, done_b, flags_b, cyc_b, fet_b, lpc_b, linst_b);
        end
        prev_b = done_b;
    end

    task automatic step(input logic r, input logic a, input logic [31:0] p,
                        input logic v, input logic e, input logic [63:0] d);
        rd = r; accept = a; pc = p; valid = v; error = e; inst = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "/A/done+flags"}, 64'({done_a, flags_a}), 64'h0);
        check({tag, "/A/counts"},     {cyc_a, fet_a}, 64'h0);
        check({tag, "/A/last_pc"},    64'(lpc_a), 64'h0);
        check({tag, "/A/last_inst"},  linst_a, 64'h0);
        check({tag, "/B/done+flags"}, 64'({done_b, flags_b}), 64'h0);
        check({tag, "/B/counts"},     {cyc_b, fet_b}, 64'h0);
        check({tag, "/B/last_pc"},    64'(lpc_b), 64'h0);
        check({tag, "/B/last_inst"},  linst_b, 64'h0);
    endtask

    // stale: drive a response during the first reset cycle.
    task automatic do_reset(input string tag, input logic stale);
        rst = 1'b1;
        step(1'b0, 1'b0, 32'h0, stale, 1'b0, inst_of(32'hDEAD0000));
        idle();
        rst = 1'b0;
        check_reset(tag);
    endtask

    task automatic finish_scenario(input string name);
        if (!done_a) begin
            n_tests++; n_fail++;
            $display("FAIL A/%s/incomplete: actual=done_o=0 required=done_o=1", name);
            if (q_a.size() != 0) void'(q_a.pop_front());
        end
        if (!done_b) begin
            n_tests++; n_fail++;
            $display("FAIL B/%s/incomplete: actual=done_o=0 required=done_o=1", name);
            if (q_b.size() != 0) void'(q_b.pop_front());
        end
        // Activity that would change every output if it were not frozen.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, PASS_PC, 1'b1, 1'b1, '1);
        do_reset({name, "/post_reset"}, 1'b0);
    endtask

    task automatic push_both(input exp_t e);
        q_a.push_back(e);
        q_b.push_back(e);
    endtask

    initial begin
        logic [31:0] p;

        idle();
        do_reset("initial", 1'b0);

        // Sequential 8-byte fetches, each answered one cycle later, up to PASS_PC.
        push_both(mk("pass", F_PASS, 32'd39, 32'd39, PASS_PC, inst_of(32'h80000128)));
        for (int i = 0; i < 38; i++) begin
            p = 32'h80000000 + 32'(8 * i);
            step(1'b1, 1'b1, p, (i > 0), 1'b0, inst_of(p - 32'd8));
        end
        step(1'b1, 1'b1, PASS_PC, 1'b1, 1'b0, inst_of(32'h80000128));
        finish_scenario("pass");

        // FAIL_PC accepted in the same cycle as an error response.
        push_both(mk("fail", F_FAIL, 32'd2, 32'd2, FAIL_PC, inst_of(32'h80000100)));
        step(1'b1, 1'b1, 32'h80000100, 1'b0, 1'b0, 64'h0);
        step(1'b1, 1'b1, FAIL_PC, 1'b1, 1'b1, inst_of(32'h80000100));
        finish_scenario("fail");

        // Response while IDLE.
        push_both(mk("proto_idle_resp", F_PROTO, 32'd0, 32'd0, 32'h0, 64'h0));
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0);
        finish_scenario("proto_idle_resp");

        // PASS_PC accept with an unexcused response: proto wins over pass.
        push_both(mk("proto_over_pass", F_PROTO, 32'd1, 32'd1, PASS_PC, 64'h0));
        step(1'b1, 1'b1, PASS_PC, 1'b1, 1'b0, 64'h0);
        finish_scenario("proto_over_pass");

        // Extra response in RUN after the only fetch was answered.
        push_both(mk("proto_resp_run", F_PROTO, 32'd3, 32'd1, 32'h80000000,
                     inst_of(32'h80000000)));
        step(1'b1, 1'b1, 32'h80000000, 1'b0, 1'b0, 64'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, inst_of(32'h80000000));
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, inst_of(32'h80000000));
        finish_scenario("proto_resp_run");

        // Three unanswered accepts with MAX_OUTSTANDING = 2.
        push_both(mk("proto_overflow", F_PROTO, 32'd3, 32'd3, 32'h80000010, 64'h0));
        step(1'b1, 1'b1, 32'h80000000, 1'b0, 1'b0, 64'h0);
        step(1'b1, 1'b1, 32'h80000008, 1'b0, 1'b0, 64'h0);
        step(1'b1, 1'b1, 32'h80000010, 1'b0, 1'b0, 64'h0);
        finish_scenario("proto_overflow");

        // accept without rd.
        push_both(mk("proto_stray_accept", F_PROTO, 32'd2, 32'd1, 32'h80000000, 64'h0));
        step(1'b1, 1'b1, 32'h80000000, 1'b0, 1'b0, 64'h0);
        step(1'b0, 1'b1, 32'h80000008, 1'b0, 1'b0, 64'h0);
        finish_scenario("proto_stray_accept");

        // One fetch then silence: A times out at cycle 1000, B hangs at 17.
        q_a.push_back(mk("timeout", F_TOUT, 32'd1000, 32'd1, 32'h80000010, 64'h0));
        q_b.push_back(mk("timeout", F_HANG, 32'd17, 32'd1, 32'h80000010, 64'h0));
        step(1'b1, 1'b1, 32'h80000010, 1'b0, 1'b0, 64'h0);
        for (int i = 0; i < 1100 && !(done_a && done_b); i++) idle();
        finish_scenario("timeout");

        // Self-loop refetch: B hangs after 16 stalls, A eventually times out.
        q_a.push_back(mk("self_loop", F_TOUT, 32'd1000, 32'd1000, 32'h80000040,
                         inst_of(32'h80000040)));
        q_b.push_back(mk("self_loop", F_HANG, 32'd17, 32'd17, 32'h80000040,
                         inst_of(32'h80000040)));
        step(1'b1, 1'b1, 32'h80000040, 1'b0, 1'b0, 64'h0);
        for (int i = 0; i < 1100 && !(done_a && done_b); i++)
            step(1'b1, 1'b1, 32'h80000040, 1'b1, 1'b0, inst_of(32'h80000040));
        finish_scenario("self_loop");

        // Reset mid-fetch with a stale response, then a clean short pass run.
        step(1'b1, 1'b1, 32'h80000000, 1'b0, 1'b0, 64'h0);
        do_reset("mid_run_reset", 1'b1);
        push_both(mk("pass_after_reset", F_PASS, 32'd3, 32'd3, PASS_PC,
                     inst_of(32'h80000128)));
        step(1'b1, 1'b1, 32'h80000120, 1'b0, 1'b0, 64'h0);
        step(1'b1, 1'b1, 32'h80000128, 1'b1, 1'b0, inst_of(32'h80000120));
        step(1'b1, 1'b1, PASS_PC, 1'b1, 1'b0, inst_of(32'h80000128));
        finish_scenario("pass_after_reset");

        repeat (3) idle();
        check("scoreboard_drained", 64'(q_a.size() + q_b.size()), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
